gsim_band_solver: RTL and testbench
===================================

// Module: gsim_band_solver
// PURPOSE
//  Parametrised Gauss-Seidel solver for the N-variable banded Toeplitz system
//  with diagonals 1,-6,13,20,13,-6,1; solves A*x = b.
//  Loads N signed b values serially, then runs sweeps until the convergence
//  tolerance is met or the sweep limit is reached. Streams the N results out.
//  Successor of the fixed 16-variable/70-round solver: adds a runtime sweep
//  limit, early exit on convergence, signed data and exact division.
// PARAMETERS
//  N      16  number of unknowns (>=4)
//  BW     16  b_in width, signed integer
//  XW     32  x width, signed fixed point, FRAC fractional bits
//  FRAC   16  fractional bits of x
//  ITW     8  width of iter_max / sweeps_done
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high
//  in_en        in   1      b_in valid; accepted only when in_ready=1
//  b_in         in   BW     signed b_i, received in index order 0..N-1
//  iter_max     in   ITW    sweep limit, sampled on first accepted b; 0 => 1
//  tol          in   XW     unsigned convergence tolerance (LSBs of x); 0 => off
//  in_ready     out  1      high in RECEIVE state
//  out_valid    out  1      high for exactly N consecutive cycles per solve
//  out_idx      out  clog2N index of x_out
//  x_out        out  XW     signed result x_i
//  sweeps_done  out  ITW    sweeps executed; valid while out_valid=1
// BEHAVIOUR
//  Reset: state=RECEIVE, in_ready=1, out_valid=0, out_idx=0, x_out=0,
//   sweeps_done=0, all internal counters 0. Mid-solve reset aborts the solve.
//  RECEIVE: each cycle with in_en=1 stores b[cnt], cnt++. After b[N-1]: x[*]=0,
//   cnt=0, go to CALC. in_en outside RECEIVE is ignored; no data is lost.
//  CALC: variables update in order 0..N-1, in place (Gauss-Seidel). Each update
//   takes exactly 4 cycles (fetch, MAC, divide, write-back).
//   num = (b_i<<FRAC) + 13*(x[i-1]+x[i+1]) - 6*(x[i-2]+x[i+2]) + (x[i-3]+x[i+3])
//   Neighbours outside 0..N-1 read 0. num is computed at XW+8 bits (no overflow).
//   x_i = num/20, truncating toward zero, then saturated to the signed XW range.
//   Track maxd = max |x_i_new - x_i_old| over the sweep.
//  End of sweep (write of x[N-1]): sweeps++.
//   If sweeps==iter_max_eff, or (tol!=0 and maxd<=tol), go to SEND.
//   Otherwise clear maxd and restart at i=0.
//   CALC length is exactly 4*N*sweeps cycles.
//  SEND: N cycles with out_valid=1, out_idx=0..N-1, x_out=x[out_idx] (registered).
//   The cycle after the last output: out_valid=0, state=RECEIVE, in_ready=1.
//   b/x storage is retained until the next solve overwrites it.
//  The first b of the next solve may be accepted the cycle after out_valid falls.
// TESTING
//  1) b all 0, iter_max=5, tol=0 -> 16 outputs of 0x00000000, sweeps_done=5,
//     CALC lasts 320 cycles.
//  2) b all 20, iter_max=1 -> x_out[0]=0x00010000 (1.0),
//     x_out[1]=0x0001A666 (33/20 truncated).
//  3) b all 0, iter_max=200, tol=1 -> early exit, sweeps_done=1.
//  4) b_i=-20 for all i, iter_max=1 -> x_out[0]=0xFFFF0000 (-1.0);
//     division truncates toward zero; results match the golden model bit-exact.
//  5) Assert reset mid-CALC, then reload b=20s -> out_valid stays 0 until
//     the new solve; results match test 2.
//  6) Hold in_en=1 through CALC/SEND -> ignored; out_idx runs 0..15 with no
//     gaps; back-to-back solves are correct.

Source files
------------

// File: rtl/gsim_band_if.sv
// Handshake bundle for gsim_band_solver.
//   master (stimulus side) drives: in_en, b_in, iter_max, tol
//   slave  (solver side)   drives: in_ready, out_valid, out_idx, x_out, sweeps_done
// The parameter defaults must match the solver instance that uses this bundle.
interface gsim_band_if #(
    parameter int N   = 16,
    parameter int BW  = 16,
    parameter int XW  = 32,
    parameter int ITW = 8
);
    localparam int IW = $clog2(N);

    logic                  in_en;
    logic signed [BW-1:0]  b_in;
    logic [ITW-1:0]        iter_max;
    logic [XW-1:0]         tol;
    logic                  in_ready;
    logic                  out_valid;
    logic [IW-1:0]         out_idx;
    logic signed [XW-1:0]  x_out;
    logic [ITW-1:0]        sweeps_done;

    modport master (
        output in_en, b_in, iter_max, tol,
        input  in_ready, out_valid, out_idx, x_out, sweeps_done
    );

    modport slave (
        input  in_en, b_in, iter_max, tol,
        output in_ready, out_valid, out_idx, x_out, sweeps_done
    );
endinterface

// File: rtl/gsim_band_solver.sv
// Gauss-Seidel solver for the N-variable banded Toeplitz system with
// diagonals 1,-6,13,20,13,-6,1. Receives N signed b values, sweeps until the
// tolerance is met or the sweep limit is hit, then streams the N results.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high; aborts any solve in progress
//   bus    - gsim_band_if.slave: b input stream, iter_max/tol, result stream
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_RECEIVE | accepting b[0..N-1]; in_ready=1
// S_CALC    | sweeping; each variable takes fetch, MAC, divide, write-back
// S_SEND    | streaming x[0..N-1], one per cycle, out_valid=1
module gsim_band_solver #(
    parameter int N    = 16,
    parameter int BW   = 16,
    parameter int XW   = 32,
    parameter int FRAC = 16,
    parameter int ITW  = 8
) (
    input  logic         clk,
    input  logic         reset,
    gsim_band_if.slave   bus
);
    localparam int IW = $clog2(N);
    // Numerator width: 13*2 + 6*2 + 2 + 1 full-scale terms stay well inside 8 guard bits.
    localparam int NW = XW + 8;

    localparam logic [IW-1:0]        LAST  = IW'(N - 1);
    localparam logic signed [NW-1:0] X_MAX = {{(NW-XW+1){1'b0}}, {(XW-1){1'b1}}};
    localparam logic signed [NW-1:0] X_MIN = {{(NW-XW+1){1'b1}}, {(XW-1){1'b0}}};
    localparam logic signed [NW-1:0] C6    = NW'(6);
    localparam logic signed [NW-1:0] C13   = NW'(13);
    localparam logic signed [NW-1:0] C20   = NW'(20);

    typedef enum logic [1:0] {S_RECEIVE, S_CALC, S_SEND} state_t;

    state_t                state_q, state_d;
    logic signed [BW-1:0]  b_mem [N];
    logic signed [XW-1:0]  x_mem [N];
    logic [IW-1:0]         cnt_q;
    logic [1:0]            phase_q;
    logic [ITW-1:0]        sweeps_q;
    logic [ITW-1:0]        iter_eff_q;
    logic [XW-1:0]         tol_q;
    logic [XW:0]           maxd_q;
    logic signed [NW-1:0]  bq_q, s1_q, s2_q, s3_q, num_q;
    logic signed [XW-1:0]  q_q;
    logic                  out_valid_q;
    logic [IW-1:0]         out_idx_q;
    logic signed [XW-1:0]  x_out_q;

    logic                  accept, sweep_end, calc_done, send_last, converged;
    logic [ITW-1:0]        sweeps_inc;
    logic signed [NW-1:0]  quo;
    logic signed [XW-1:0]  q_sat;
    logic signed [XW:0]    diff;
    logic [XW:0]           absd, maxd_new;

    // Neighbour read with the zero boundary outside 0..N-1.
    function automatic logic signed [XW-1:0] nbr(input int j);
        if (j < 0 || j >= N) return '0;
        return x_mem[j[IW-1:0]];
    endfunction

    // SV signed division truncates toward zero, which is the required rounding.
    assign quo        = num_q / C20;
    assign sweeps_inc = sweeps_q + 1'b1;

    always_comb begin
        q_sat = quo[XW-1:0];
        if (quo > X_MAX)      q_sat = X_MAX[XW-1:0];
        else if (quo < X_MIN) q_sat = X_MIN[XW-1:0];
    end

    // Change of the variable being written; one extra bit so the full
    // signed range difference cannot wrap.
    always_comb begin
        diff      = {q_q[XW-1], q_q} - {x_mem[cnt_q][XW-1], x_mem[cnt_q]};
        absd      = diff[XW] ? $unsigned(-diff) : $unsigned(diff);
        maxd_new  = (absd > maxd_q) ? absd : maxd_q;
        converged = (tol_q != '0) && (maxd_new <= {1'b0, tol_q});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_RECEIVE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        sweep_end = 1'b0;
        calc_done = 1'b0;
        send_last = 1'b0;
        case (state_q)
            S_RECEIVE: begin
                if (bus.in_en) begin
                    accept = 1'b1;
                    if (cnt_q == LAST) state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (phase_q == 2'd3 && cnt_q == LAST) begin
                    sweep_end = 1'b1;
                    if (sweeps_inc == iter_eff_q || converged) begin
                        calc_done = 1'b1;
                        state_d   = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (out_idx_q == LAST) begin
                    send_last = 1'b1;
                    state_d   = S_RECEIVE;
                end
            end
            default: state_d = S_RECEIVE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                b_mem[k] <= '0;
                x_mem[k] <= '0;
            end
            cnt_q       <= '0;
            phase_q     <= '0;
            sweeps_q    <= '0;
            iter_eff_q  <= '0;
            tol_q       <= '0;
            maxd_q      <= '0;
            bq_q        <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            num_q       <= '0;
            q_q         <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            x_out_q     <= '0;
        end else begin
            if (accept) begin
                b_mem[cnt_q] <= bus.b_in;
                if (cnt_q == '0) begin
                    iter_eff_q <= (bus.iter_max == '0) ? ITW'(1) : bus.iter_max;
                    tol_q      <= bus.tol;
                end
                if (cnt_q == LAST) begin
                    cnt_q    <= '0;
                    phase_q  <= '0;
                    sweeps_q <= '0;
                    maxd_q   <= '0;
                    for (int k = 0; k < N; k++) x_mem[k] <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            if (state_q == S_CALC) begin
                phase_q <= phase_q + 1'b1;
                case (phase_q)
                    2'd0: begin
                        bq_q <= NW'(b_mem[cnt_q]) <<< FRAC;
                        s1_q <= NW'(nbr(int'(cnt_q) - 1)) + NW'(nbr(int'(cnt_q) + 1));
                        s2_q <= NW'(nbr(int'(cnt_q) - 2)) + NW'(nbr(int'(cnt_q) + 2));
                        s3_q <= NW'(nbr(int'(cnt_q) - 3)) + NW'(nbr(int'(cnt_q) + 3));
                    end
                    2'd1: num_q <= bq_q + s1_q * C13 - s2_q * C6 + s3_q;
                    2'd2: q_q <= q_sat;
                    default: begin
                        x_mem[cnt_q] <= q_q;
                        if (sweep_end) begin
                            sweeps_q <= sweeps_inc;
                            cnt_q    <= '0;
                            maxd_q   <= '0;
                        end else begin
                            cnt_q  <= cnt_q + 1'b1;
                            maxd_q <= maxd_new;
                        end
                    end
                endcase
            end

            // x[0] is final at this point; only x[N-1] is still being written.
            if (calc_done) begin
                out_valid_q <= 1'b1;
                out_idx_q   <= '0;
                x_out_q     <= x_mem[0];
            end

            if (state_q == S_SEND) begin
                if (send_last) begin
                    out_valid_q <= 1'b0;
                    out_idx_q   <= '0;
                end else begin
                    out_idx_q <= out_idx_q + 1'b1;
                    x_out_q   <= x_mem[out_idx_q + 1'b1];
                end
            end
        end
    end

    assign bus.in_ready    = (state_q == S_RECEIVE);
    assign bus.out_valid   = out_valid_q;
    assign bus.out_idx     = out_idx_q;
    assign bus.x_out       = x_out_q;
    assign bus.sweeps_done = sweeps_q;
endmodule

// File: tb/tb_gsim_band_solver.sv
module tb_gsim_band_solver;
    localparam int N   = 16;
    localparam int BW  = 16;
    localparam int XW  = 32;
    localparam int ITW = 8;
    localparam longint XMAXL = 64'sd2147483647;
    localparam longint XMINL = -64'sd2147483648;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gsim_band_if #(.N(N), .BW(BW), .XW(XW), .ITW(ITW)) bus ();

    gsim_band_solver #(.N(N), .BW(BW), .XW(XW), .FRAC(16), .ITW(ITW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    longint         bv [N];
    longint         mdl_x [N];
    int             mdl_sw;
    logic [XW-1:0]  got_x [N];
    logic [ITW-1:0] got_sw;
    int             calc_cyc;
    int             guard;
    bit             ov_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint xg(input int j);
        if (j < 0 || j >= N) return 0;
        return mdl_x[j];
    endfunction

    task automatic run_model(input int itm, input longint tolv);
        longint num, q, d, maxd;
        int eff;
        bit done;
        for (int i = 0; i < N; i++) mdl_x[i] = 0;
        eff = (itm == 0) ? 1 : itm;
        mdl_sw = 0;
        done = 0;
        while (!done) begin
            maxd = 0;
            for (int i = 0; i < N; i++) begin
                num = bv[i] * 65536 + 13 * (xg(i-1) + xg(i+1))
                      - 6 * (xg(i-2) + xg(i+2)) + (xg(i-3) + xg(i+3));
                q = num / 20;
                if (q > XMAXL) q = XMAXL;
                if (q < XMINL) q = XMINL;
                d = q - mdl_x[i];
                if (d < 0) d = -d;
                if (d > maxd) maxd = d;
                mdl_x[i] = q;
            end
            mdl_sw++;
            if (mdl_sw == eff || (tolv != 0 && maxd <= tolv)) done = 1;
        end
    endtask

    task automatic cmp_model(input string tag);
        logic [XW-1:0] e;
        for (int i = 0; i < N; i++) begin
            e = XW'(mdl_x[i]);
            chk($sformatf("%s_x%0d", tag, i), got_x[i], e);
        end
        chk({tag, "_sweeps"}, got_sw, ITW'(mdl_sw));
    endtask

    task automatic load(input int itm, input logic [XW-1:0] tolv, input bit hold);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (i == 0) chk("load_ready", bus.in_ready, 1);
            bus.in_en    = 1'b1;
            bus.b_in     = BW'(bv[i]);
            bus.iter_max = ITW'(itm);
            bus.tol      = tolv;
        end
        @(negedge clk);
        if (hold) bus.b_in = 16'sh7FFF;
        else      bus.in_en = 1'b0;
    endtask

    // Returns at the negedge on which the last result is presented.
    task automatic collect(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        for (int k = 0; k < N; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("%s_valid%0d", tag, k), bus.out_valid, 1);
            chk($sformatf("%s_idx%0d", tag, k), bus.out_idx, k);
            got_x[k] = bus.x_out;
            if (k == 0) got_sw = bus.sweeps_done;
        end
    endtask

    task automatic after_send(input string tag);
        @(negedge clk);
        chk({tag, "_valid_low"}, bus.out_valid, 0);
        chk({tag, "_ready_back"}, bus.in_ready, 1);
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_en    = 1'b0;
        bus.b_in     = '0;
        bus.iter_max = '0;
        bus.tol      = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_idx", bus.out_idx, 0);
        chk("rst_x", bus.x_out, 0);
        chk("rst_sweeps", bus.sweeps_done, 0);
        reset = 1'b0;

        // 1) zero b, 5 sweeps, CALC length 4*16*5
        for (int i = 0; i < N; i++) bv[i] = 0;
        load(5, 0, 0);
        calc_cyc = 0;
        guard = 0;
        while (!bus.out_valid && guard < 4000) begin
            if (!bus.in_ready) calc_cyc++;
            guard++;
            @(negedge clk);
        end
        chk("t1_calc_cycles", calc_cyc, 320);
        collect("t1");
        for (int i = 0; i < N; i++) chk($sformatf("t1_zero%0d", i), got_x[i], 32'h0);
        chk("t1_sweeps", got_sw, 5);
        after_send("t1");

        // 2) b all 20, single sweep
        for (int i = 0; i < N; i++) bv[i] = 20;
        load(1, 0, 0);
        collect("t2");
        chk("t2_x0", got_x[0], 32'h0001_0000);
        chk("t2_x1", got_x[1], 32'h0001_A666);
        chk("t2_sweeps", got_sw, 1);
        run_model(1, 0);
        cmp_model("t2m");
        after_send("t2");

        // 3) zero b, tolerance 1 -> exit after first sweep
        for (int i = 0; i < N; i++) bv[i] = 0;
        load(200, 1, 0);
        collect("t3");
        chk("t3_sweeps", got_sw, 1);
        chk("t3_x5", got_x[5], 32'h0);
        after_send("t3");

        // 4) b all -20, truncation toward zero
        for (int i = 0; i < N; i++) bv[i] = -20;
        load(1, 0, 0);
        collect("t4");
        chk("t4_x0", got_x[0], 32'hFFFF_0000);
        chk("t4_x1", got_x[1], 32'hFFFE_599A);
        run_model(1, 0);
        cmp_model("t4m");
        after_send("t4");

        // mixed b: iter_max=0 behaves as 1, then a long run that may saturate
        bv = '{100, -250, 37, 0, -1, 999, -32768, 32767, 5, -5, 12, -300, 7000, -7000, 1, -2};
        load(0, 0, 0);
        collect("mix1");
        run_model(0, 0);
        cmp_model("mix1m");
        after_send("mix1");
        load(12, 0, 0);
        collect("mix12");
        run_model(12, 0);
        cmp_model("mix12m");
        after_send("mix12");

        // 5) reset during CALC, then a fresh solve
        for (int i = 0; i < N; i++) bv[i] = 20;
        load(200, 0, 0);
        ov_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.out_valid) ov_seen = 1;
        end
        chk("t5_no_early_valid", ov_seen, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rst_ready", bus.in_ready, 1);
        chk("t5_rst_valid", bus.out_valid, 0);
        chk("t5_rst_sweeps", bus.sweeps_done, 0);
        reset = 1'b0;
        load(1, 0, 0);
        collect("t5");
        chk("t5_x0", got_x[0], 32'h0001_0000);
        chk("t5_x1", got_x[1], 32'h0001_A666);
        run_model(1, 0);
        cmp_model("t5m");
        after_send("t5");

        // 6) in_en held high through CALC/SEND, back-to-back solves
        load(1, 0, 1);
        collect("t6a");
        run_model(1, 0);
        cmp_model("t6am");
        bus.b_in = 16'sd20;
        after_send("t6a");
        repeat (N) @(negedge clk);
        bus.b_in = 16'sh7FFF;
        collect("t6b");
        cmp_model("t6bm");
        bus.in_en = 1'b0;
        after_send("t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
